// File: rtl/stream_pkg.sv
// Shared definitions for the stream demux slice.
//   DATA_W    : default data width of a stream word
//   clog2()   : constant-foldable log2 used to size pointers
//   in_beat_t : one input beat, a data word plus its output select
package stream_pkg;

  localparam int DATA_W = 32;

  // Usable inside parameter and localparam expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sel;
  } in_beat_t;

endpackage

// File: rtl/demux_out_fifo.sv
// Per-output queue of the stream demux.
//   clk, rst_n : clock, async active-low reset
//   push       : write push_data at the tail (ignored when full)
//   push_data  : word to enqueue
//   pop        : advance the head (ignored when empty)
//   full/empty : occupancy flags, derived from registered state only
//   head       : current head word; holds the last head once drained
module demux_out_fifo
  import stream_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] OCC_ONE  = (AW+1)'(1);
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               rd_ptr, wr_ptr;
  logic [AW:0]                 occ;
  logic [WIDTH-1:0]            head_q;
  logic                        do_push, do_pop;

  assign full    = (occ == OCC_FULL);
  assign empty   = (occ == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = head_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      head_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;

      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase

      // head is a register so it keeps the last word shown after draining
      // rather than exposing a stale memory slot.
      if (do_pop) begin
        if (occ > OCC_ONE)  head_q <= mem[rd_ptr + 1'b1];
        else if (do_push)   head_q <= push_data;
      end else if (do_push && empty) begin
        head_q <= push_data;
      end
    end
  end

endmodule

// File: rtl/stream_demux_1x2.sv
// 1-to-2 valid/ready stream demux with a small queue per output.
//   Clk, Reset_n         : clock, async active-low reset
//   In_Data/Sel/Valid    : input beat; Sel picks output 0 or 1
//   In_Ready             : selected queue has room (registered state only)
//   OutX_Data/Valid      : head of queue X / queue X non-empty
//   OutX_Ready           : consumer X takes the head
//   Cnt0/Cnt1            : wrapping count of words accepted for each output
module stream_demux_1x2
  import stream_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] In_Data,
  input  logic             In_Sel,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [WIDTH-1:0] Out0_Data,
  output logic             Out0_Valid,
  input  logic             Out0_Ready,
  output logic [WIDTH-1:0] Out1_Data,
  output logic             Out1_Valid,
  input  logic             Out1_Ready,
  output logic [CNT_W-1:0] Cnt0,
  output logic [CNT_W-1:0] Cnt1
);

  localparam int NUM_OUT = 2;

  logic [NUM_OUT-1:0]            push, pop, full, empty, rdy_out;
  logic [NUM_OUT-1:0][WIDTH-1:0] head;
  logic [NUM_OUT-1:0][CNT_W-1:0] cnt;
  logic                          accept;

  // Gated by Reset_n so nothing is taken while reset is held.
  assign In_Ready = Reset_n & ~full[In_Sel];
  assign accept   = In_Valid & In_Ready;
  assign rdy_out  = {Out1_Ready, Out0_Ready};

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
    assign push[i] = accept & (In_Sel == 1'(i));
    assign pop[i]  = ~empty[i] & rdy_out[i];

    demux_out_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk       (Clk),
      .rst_n     (Reset_n),
      .push      (push[i]),
      .push_data (In_Data),
      .pop       (pop[i]),
      .full      (full[i]),
      .empty     (empty[i]),
      .head      (head[i])
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)     cnt[i] <= '0;
      else if (push[i]) cnt[i] <= cnt[i] + 1'b1;
    end
  end

  assign Out0_Data  = head[0];
  assign Out1_Data  = head[1];
  assign Out0_Valid = ~empty[0];
  assign Out1_Valid = ~empty[1];
  assign Cnt0       = cnt[0];
  assign Cnt1       = cnt[1];

endmodule

// File: tb/tb_stream_demux_1x2.sv
module tb_stream_demux_1x2;
  import stream_pkg::*;

  localparam int W  = 32;
  localparam int D  = 2;
  localparam int CW = 4;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic [W-1:0]  In_Data;
  logic          In_Sel, In_Valid, In_Ready;
  logic [W-1:0]  Out0_Data, Out1_Data;
  logic          Out0_Valid, Out1_Valid, Out0_Ready, Out1_Ready;
  logic [CW-1:0] Cnt0, Cnt1;

  stream_demux_1x2 #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .In_Data(In_Data), .In_Sel(In_Sel), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Out0_Data(Out0_Data), .Out0_Valid(Out0_Valid), .Out0_Ready(Out0_Ready),
    .Out1_Data(Out1_Data), .Out1_Valid(Out1_Valid), .Out1_Ready(Out1_Ready),
    .Cnt0(Cnt0), .Cnt1(Cnt1)
  );

  always #5 Clk = ~Clk;

  // Reference model: one queue per output plus the word last shown on each.
  logic [W-1:0] q0[$], q1[$];
  logic [W-1:0] last0, last1;
  int unsigned  mc0, mc1;
  logic         exp_rdy;
  int           n_chk, n_fail;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete();
    last0 = '0; last1 = '0; mc0 = 0; mc1 = 0;
  endtask

  task automatic model_check();
    exp_rdy = (In_Sel ? q1.size() : q0.size()) < D;
    chk("in_ready",   {31'd0, In_Ready},   {31'd0, exp_rdy});
    chk("out0_valid", {31'd0, Out0_Valid}, (q0.size() != 0) ? 32'd1 : 32'd0);
    chk("out0_data",  Out0_Data, (q0.size() != 0) ? q0[0] : last0);
    chk("out1_valid", {31'd0, Out1_Valid}, (q1.size() != 0) ? 32'd1 : 32'd0);
    chk("out1_data",  Out1_Data, (q1.size() != 0) ? q1[0] : last1);
    chk("cnt0", {28'd0, Cnt0}, mc0);
    chk("cnt1", {28'd0, Cnt1}, mc1);
  endtask

  // Called at a falling edge: drive inputs, then check against the model.
  task automatic drive(input logic v, input logic s, input logic [W-1:0] d,
                       input logic r0, input logic r1);
    In_Valid = v; In_Sel = s; In_Data = d; Out0_Ready = r0; Out1_Ready = r1;
    #1;
    model_check();
  endtask

  // Cross the rising edge and apply the same transfer rules to the model.
  task automatic advance();
    logic acc, p0, p1;
    acc = In_Valid && exp_rdy;
    p0  = (q0.size() != 0) && Out0_Ready;
    p1  = (q1.size() != 0) && Out1_Ready;
    @(posedge Clk);
    if (p0) void'(q0.pop_front());
    if (p1) void'(q1.pop_front());
    if (acc) begin
      if (In_Sel) begin q1.push_back(In_Data); mc1 = (mc1 + 1) % (1 << CW); end
      else        begin q0.push_back(In_Data); mc0 = (mc0 + 1) % (1 << CW); end
    end
    if (q0.size() != 0) last0 = q0[0];
    if (q1.size() != 0) last1 = q1[0];
    @(negedge Clk);
  endtask

  typedef struct {
    logic v, s; logic [31:0] d; logic r0, r1;
    logic rdy, v0; logic [31:0] d0; logic v1; logic [31:0] d1;
    int c0, c1;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic     stall;
    in_beat_t beat;
    logic     rv, r0, r1;
    n_chk = 0; n_fail = 0;
    model_reset();
    Reset_n = 1'b0; In_Valid = 0; In_Sel = 0; In_Data = '0; Out0_Ready = 0; Out1_Ready = 0;

    //            v  s  data     r0 r1 | rdy v0 d0       v1 d1     c0 c1
    tbl[0]  = '{1, 0, 5,        1, 1,   1,  0, 0,       0, 0,     0, 0};
    tbl[1]  = '{1, 1, 10,       1, 1,   1,  1, 5,       0, 0,     1, 0};
    tbl[2]  = '{0, 0, 0,        1, 1,   1,  0, 5,       1, 10,    1, 1};
    tbl[3]  = '{1, 0, 50,       0, 1,   1,  0, 5,       0, 10,    1, 1};
    tbl[4]  = '{1, 0, 7,        0, 1,   1,  1, 50,      0, 10,    2, 1};
    tbl[5]  = '{1, 0, 1000000,  0, 1,   0,  1, 50,      0, 10,    3, 1};
    tbl[6]  = '{1, 0, 1000000,  1, 1,   0,  1, 50,      0, 10,    3, 1};
    tbl[7]  = '{1, 0, 1000000,  1, 1,   1,  1, 7,       0, 10,    3, 1};
    tbl[8]  = '{0, 0, 0,        1, 1,   1,  1, 1000000, 0, 10,    4, 1};
    tbl[9]  = '{1, 0, 11,       0, 0,   1,  0, 1000000, 0, 10,    4, 1};
    tbl[10] = '{1, 0, 12,       0, 0,   1,  1, 11,      0, 10,    5, 1};
    tbl[11] = '{1, 1, 34991,    0, 0,   1,  1, 11,      0, 10,    6, 1};
    tbl[12] = '{1, 1, 77,       0, 1,   1,  1, 11,      1, 34991, 6, 2};
    tbl[13] = '{0, 0, 0,        1, 0,   0,  1, 11,      1, 77,    6, 3};
    tbl[14] = '{0, 1, 0,        1, 1,   1,  1, 12,      1, 77,    6, 3};
    tbl[15] = '{0, 0, 0,        1, 1,   1,  0, 12,      0, 77,    6, 3};

    // Reset held: everything quiet, nothing accepted.
    repeat (2) @(negedge Clk);
    #1;
    chk("rst_in_ready", {31'd0, In_Ready}, 32'd0);
    chk("rst_out0_valid", {31'd0, Out0_Valid}, 32'd0);
    chk("rst_out0_data", Out0_Data, 32'd0);
    chk("rst_cnt0", {28'd0, Cnt0}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Directed table: routing, backpressure, independence, push+pop.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r0, tbl[i].r1);
      chk($sformatf("row%0d_rdy", i), {31'd0, In_Ready}, {31'd0, tbl[i].rdy});
      chk($sformatf("row%0d_v0", i), {31'd0, Out0_Valid}, {31'd0, tbl[i].v0});
      chk($sformatf("row%0d_d0", i), Out0_Data, tbl[i].d0);
      chk($sformatf("row%0d_v1", i), {31'd0, Out1_Valid}, {31'd0, tbl[i].v1});
      chk($sformatf("row%0d_d1", i), Out1_Data, tbl[i].d1);
      chk($sformatf("row%0d_c0", i), {28'd0, Cnt0}, tbl[i].c0);
      chk($sformatf("row%0d_c1", i), {28'd0, Cnt1}, tbl[i].c1);
      advance();
    end

    // Counter wrap on output 0.
    for (int k = 0; k < 40 && mc0 != 15; k++) begin
      drive(1'b1, 1'b0, $urandom, 1'b1, 1'b1);
      advance();
    end
    chk("wrap_pre_cnt0", {28'd0, Cnt0}, 32'd15);
    drive(1'b1, 1'b0, 32'h600D, 1'b1, 1'b1);
    advance();
    chk("wrap_cnt0", {28'd0, Cnt0}, 32'd0);

    // Random traffic; the producer holds its beat while stalled.
    stall = 1'b0;
    beat  = '0;
    rv    = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!stall) begin
        beat.data = $urandom;
        beat.sel  = 1'($urandom_range(0, 1));
        rv        = ($urandom_range(0, 3) != 0);
      end
      r0 = ($urandom_range(0, 2) != 0);
      r1 = ($urandom_range(0, 3) == 0);
      drive(rv, beat.sel, beat.data, r0, r1);
      stall = rv && !exp_rdy;
      advance();
    end

    // Reset mid-transfer with a word queued: outputs clear immediately.
    drive(1'b1, 1'b0, 32'hABCD, 1'b0, 1'b0);
    advance();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, In_Ready}, 32'd0);
    chk("midrst_out0_valid", {31'd0, Out0_Valid}, 32'd0);
    chk("midrst_out0_data", Out0_Data, 32'd0);
    chk("midrst_out1_valid", {31'd0, Out1_Valid}, 32'd0);
    chk("midrst_out1_data", Out1_Data, 32'd0);
    chk("midrst_cnt0", {28'd0, Cnt0}, 32'd0);
    chk("midrst_cnt1", {28'd0, Cnt1}, 32'd0);
    model_reset();
    @(negedge Clk);
    Reset_n = 1'b1;
    drive(1'b1, 1'b1, 32'h1234, 1'b1, 1'b1);
    advance();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    advance();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
